// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset control unit: state codes,
// opcodes, ALU operation codes, mux encodings and the decoded control word.
package cpu_defs_pkg;

    // HALT shares code 3'b000 with IF; a separate halt flag tells them apart.
    typedef enum logic [2:0] {
        StIf     = 3'b000,
        StId     = 3'b001,
        StExeMem = 3'b010,
        StMem    = 3'b011,
        StWbLd   = 3'b100,
        StExeBr  = 3'b101,
        StExeAl  = 3'b110,
        StWbAl   = 3'b111
    } ctrlStateE;

    localparam logic [5:0] OpAdd   = 6'b000000;
    localparam logic [5:0] OpSub   = 6'b000001;
    localparam logic [5:0] OpAddiu = 6'b000010;
    localparam logic [5:0] OpAnd   = 6'b010000;
    localparam logic [5:0] OpAndi  = 6'b010001;
    localparam logic [5:0] OpOri   = 6'b010010;
    localparam logic [5:0] OpXori  = 6'b010011;
    localparam logic [5:0] OpSll   = 6'b011000;
    localparam logic [5:0] OpSlt   = 6'b100110;
    localparam logic [5:0] OpSlti  = 6'b100111;
    localparam logic [5:0] OpSw    = 6'b110000;
    localparam logic [5:0] OpLw    = 6'b110001;
    localparam logic [5:0] OpBeq   = 6'b110100;
    localparam logic [5:0] OpBne   = 6'b110101;
    localparam logic [5:0] OpBltz  = 6'b110110;
    localparam logic [5:0] OpJ     = 6'b111000;
    localparam logic [5:0] OpJr    = 6'b111001;
    localparam logic [5:0] OpJal   = 6'b111010;
    localparam logic [5:0] OpHalt  = 6'b111111;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluSll = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluAnd = 3'b100;
    localparam logic [2:0] AluSlt = 3'b101;
    localparam logic [2:0] AluXor = 3'b110;

    localparam logic [1:0] PcNext   = 2'b00;
    localparam logic [1:0] PcBranch = 2'b01;
    localparam logic [1:0] PcReg    = 2'b10;
    localparam logic [1:0] PcJump   = 2'b11;

    localparam logic [1:0] DstRa = 2'b00;
    localparam logic [1:0] DstRt = 2'b01;
    localparam logic [1:0] DstRd = 2'b10;

    typedef struct packed {
        logic       pcWre;
        logic       irWre;
        logic       aluSrcA;
        logic       aluSrcB;
        logic [2:0] aluOp;
        logic       extSel;
        logic       regWre;
        logic [1:0] regDst;
        logic       wrRegDSrc;
        logic       dbDataSrc;
        logic       mRd;
        logic       mWr;
        logic [1:0] pcSrc;
    } ctrlWordT;

    function automatic logic isRAlu(logic [5:0] op);
        return op inside {OpAdd, OpSub, OpAnd, OpSll, OpSlt};
    endfunction

    function automatic logic isIAlu(logic [5:0] op);
        return op inside {OpAddiu, OpAndi, OpOri, OpXori, OpSlti};
    endfunction

    function automatic logic [2:0] aluOpOf(logic [5:0] op);
        logic [2:0] res;
        case (op)
            OpSub:          res = AluSub;
            OpSll:          res = AluSll;
            OpOri:          res = AluOr;
            OpAnd, OpAndi:  res = AluAnd;
            OpSlt, OpSlti:  res = AluSlt;
            OpXori:         res = AluXor;
            default:        res = AluAdd;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational half of the control FSM: current state, halt flag, opcode and
// ALU flags in; control word, next state and next halt flag out.
module ctrl_decode
    import cpu_defs_pkg::*;
(
    input  ctrlStateE  state,
    input  logic       halted,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       sign,
    output ctrlWordT   ctrl,
    output ctrlStateE  nextState,
    output logic       nextHalt
);

    // Decode the control word and the next state from the current state.
    always_comb begin
        ctrl      = '0;
        nextState = state;
        nextHalt  = halted;
        if (halted) begin
            // Absorbing: everything stays deasserted until Reset.
            nextState = StIf;
        end else begin
            unique case (state)
                StIf: begin
                    ctrl.irWre = 1'b1;
                    nextState  = StId;
                end
                StId: begin
                    case (opcode)
                        OpJ: begin
                            ctrl.pcWre = 1'b1;
                            ctrl.pcSrc = PcJump;
                            nextState  = StIf;
                        end
                        OpJal: begin
                            ctrl.pcWre     = 1'b1;
                            ctrl.pcSrc     = PcJump;
                            ctrl.regWre    = 1'b1;
                            ctrl.regDst    = DstRa;
                            ctrl.wrRegDSrc = 1'b0;
                            nextState      = StIf;
                        end
                        OpJr: begin
                            ctrl.pcWre = 1'b1;
                            ctrl.pcSrc = PcReg;
                            nextState  = StIf;
                        end
                        OpHalt: begin
                            nextHalt  = 1'b1;
                            nextState = StIf;
                        end
                        OpBeq, OpBne, OpBltz: nextState = StExeBr;
                        OpSw, OpLw:           nextState = StExeMem;
                        default: begin
                            if (isRAlu(opcode) || isIAlu(opcode)) begin
                                nextState = StExeAl;
                            end else begin
                                // Unknown opcode retires as a NOP.
                                ctrl.pcWre = 1'b1;
                                nextState  = StIf;
                            end
                        end
                    endcase
                end
                StExeAl: begin
                    ctrl.aluSrcA = (opcode == OpSll);
                    ctrl.aluSrcB = isIAlu(opcode);
                    ctrl.extSel  = (opcode == OpAddiu) || (opcode == OpSlti);
                    ctrl.aluOp   = aluOpOf(opcode);
                    nextState    = StWbAl;
                end
                StWbAl: begin
                    ctrl.regWre    = 1'b1;
                    ctrl.wrRegDSrc = 1'b1;
                    ctrl.regDst    = isIAlu(opcode) ? DstRt : DstRd;
                    ctrl.pcWre     = 1'b1;
                    nextState      = StIf;
                end
                StExeBr: begin
                    ctrl.aluOp  = (opcode == OpBltz) ? AluSlt : AluSub;
                    // Branch offset is a signed word displacement.
                    ctrl.extSel = 1'b1;
                    if ((opcode == OpBeq && zero) || (opcode == OpBne && !zero) ||
                        (opcode == OpBltz && sign)) begin
                        ctrl.pcSrc = PcBranch;
                    end else begin
                        ctrl.pcSrc = PcNext;
                    end
                    ctrl.pcWre = 1'b1;
                    nextState  = StIf;
                end
                StExeMem: begin
                    ctrl.aluSrcB = 1'b1;
                    ctrl.extSel  = 1'b1;
                    ctrl.aluOp   = AluAdd;
                    nextState    = StMem;
                end
                StMem: begin
                    if (opcode == OpSw) begin
                        ctrl.mWr   = 1'b1;
                        ctrl.pcWre = 1'b1;
                        nextState  = StIf;
                    end else begin
                        ctrl.mRd  = 1'b1;
                        nextState = StWbLd;
                    end
                end
                StWbLd: begin
                    ctrl.regWre    = 1'b1;
                    ctrl.dbDataSrc = 1'b1;
                    ctrl.wrRegDSrc = 1'b1;
                    ctrl.regDst    = DstRt;
                    ctrl.pcWre     = 1'b1;
                    nextState      = StIf;
                end
            endcase
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control unit: state register, halt flag and retired-instruction
// counter; the control word itself comes from ctrl_decode.
module multicycle_ctrl
    import cpu_defs_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             sign,
    output logic             PCWre,
    output logic             IRWre,
    output logic             ALUSrcA,
    output logic             ALUSrcB,
    output logic [2:0]       ALUOp,
    output logic             ExtSel,
    output logic             RegWre,
    output logic [1:0]       RegDst,
    output logic             WrRegDSrc,
    output logic             DBDataSrc,
    output logic             mRD,
    output logic             mWR,
    output logic [1:0]       PCSrc,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_cnt,
    output logic             halted
);

    ctrlStateE        stateQ, stateD;
    logic             haltQ, haltD;
    logic [CNT_W-1:0] instrCntQ, instrCntD;
    ctrlWordT         ctrl, ctrlOut;

    ctrl_decode uDecode (
        .state     (stateQ),
        .halted    (haltQ),
        .opcode    (opcode),
        .zero      (zero),
        .sign      (sign),
        .ctrl      (ctrl),
        .nextState (stateD),
        .nextHalt  (haltD)
    );

    // Hold every control output low while Reset is asserted.
    always_comb begin
        ctrlOut = ctrl;
        if (Reset) begin
            ctrlOut = '0;
        end
    end

    // One instruction retires on each PCWre cycle; the counter wraps silently.
    always_comb begin
        instrCntD = instrCntQ + CNT_W'(ctrlOut.pcWre);
    end

    // State, halt flag and counter registers.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            stateQ    <= StIf;
            haltQ     <= 1'b0;
            instrCntQ <= '0;
        end else begin
            stateQ    <= stateD;
            haltQ     <= haltD;
            instrCntQ <= instrCntD;
        end
    end

    assign PCWre     = ctrlOut.pcWre;
    assign IRWre     = ctrlOut.irWre;
    assign ALUSrcA   = ctrlOut.aluSrcA;
    assign ALUSrcB   = ctrlOut.aluSrcB;
    assign ALUOp     = ctrlOut.aluOp;
    assign ExtSel    = ctrlOut.extSel;
    assign RegWre    = ctrlOut.regWre;
    assign RegDst    = ctrlOut.regDst;
    assign WrRegDSrc = ctrlOut.wrRegDSrc;
    assign DBDataSrc = ctrlOut.dbDataSrc;
    assign mRD       = ctrlOut.mRd;
    assign mWR       = ctrlOut.mWr;
    assign PCSrc     = ctrlOut.pcSrc;
    assign state     = stateQ;
    assign instr_cnt = instrCntQ;
    assign halted    = haltQ;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-instruction expected cycle sequences
// are queued by the stimulus and compared every cycle by an independent monitor.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic [5:0]  opcode = 6'b0;
    logic        zero = 1'b0;
    logic        sign = 1'b0;
    logic        PCWre, IRWre, ALUSrcA, ALUSrcB, ExtSel, RegWre, WrRegDSrc, DBDataSrc;
    logic        mRD, mWR, halted;
    logic [2:0]  ALUOp, state;
    logic [1:0]  RegDst, PCSrc;
    logic [31:0] instr_cnt;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero), .sign(sign),
        .PCWre(PCWre), .IRWre(IRWre), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .ExtSel(ExtSel), .RegWre(RegWre), .RegDst(RegDst),
        .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc), .mRD(mRD), .mWR(mWR),
        .PCSrc(PCSrc), .state(state), .instr_cnt(instr_cnt), .halted(halted)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [2:0]  st;
        logic        pcWre, irWre, aluSrcA, aluSrcB;
        logic [2:0]  aluOp;
        logic        extSel, regWre;
        logic [1:0]  regDst;
        logic        wrRegDSrc, dbDataSrc, mRd, mWr;
        logic [1:0]  pcSrc;
        logic        halted;
        logic [31:0] cnt;
    } obsT;

    obsT         expQ[$];
    int          checks = 0;
    int          errors = 0;
    bit          monEn = 0;
    logic [31:0] mCnt = 0;

    logic [5:0] legalOps [19] = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
        6'b010010, 6'b010011, 6'b011000, 6'b100110, 6'b100111, 6'b110000, 6'b110001,
        6'b110100, 6'b110101, 6'b110110, 6'b111000, 6'b111001, 6'b111010, 6'b101010};

    function automatic obsT sample();
        obsT g;
        g.st = state; g.pcWre = PCWre; g.irWre = IRWre; g.aluSrcA = ALUSrcA;
        g.aluSrcB = ALUSrcB; g.aluOp = ALUOp; g.extSel = ExtSel; g.regWre = RegWre;
        g.regDst = RegDst; g.wrRegDSrc = WrRegDSrc; g.dbDataSrc = DBDataSrc;
        g.mRd = mRD; g.mWr = mWR; g.pcSrc = PCSrc; g.halted = halted; g.cnt = instr_cnt;
        return g;
    endfunction

    function automatic obsT base(input logic [2:0] st);
        obsT r = '0;
        r.st  = st;
        r.cnt = mCnt;
        return r;
    endfunction

    // Reference ALU operation per opcode, straight from the opcode table.
    function automatic logic [2:0] aluRef(input logic [5:0] op);
        case (op)
            6'b000001:            return 3'd1;
            6'b011000:            return 3'd2;
            6'b010010:            return 3'd3;
            6'b010000, 6'b010001: return 3'd4;
            6'b100110, 6'b100111: return 3'd5;
            6'b010011:            return 3'd6;
            default:              return 3'd0;
        endcase
    endfunction

    // Queue the expected cycle-by-cycle outputs of one instruction and drive it.
    task automatic issue(input logic [5:0] op, input logic z, input logic s, output int n);
        obsT  r;
        bit   retire = 1;
        int   first = expQ.size();
        logic isR = op inside {6'b000000, 6'b000001, 6'b010000, 6'b011000, 6'b100110};
        logic isI = op inside {6'b000010, 6'b010001, 6'b010010, 6'b010011, 6'b100111};
        r = base(3'b000); r.irWre = 1; expQ.push_back(r);
        if (isR || isI) begin
            expQ.push_back(base(3'b001));
            r = base(3'b110);
            r.aluSrcA = (op == 6'b011000);
            r.aluSrcB = isI;
            r.extSel  = op inside {6'b000010, 6'b100111};
            r.aluOp   = aluRef(op);
            expQ.push_back(r);
            r = base(3'b111);
            r.regWre = 1; r.wrRegDSrc = 1; r.pcWre = 1;
            r.regDst = isI ? 2'b01 : 2'b10;
            expQ.push_back(r);
        end else begin
            case (op)
                6'b110000, 6'b110001: begin
                    expQ.push_back(base(3'b001));
                    r = base(3'b010); r.aluSrcB = 1; r.extSel = 1; expQ.push_back(r);
                    r = base(3'b011);
                    if (op == 6'b110000) begin
                        r.mWr = 1; r.pcWre = 1; expQ.push_back(r);
                    end else begin
                        r.mRd = 1; expQ.push_back(r);
                        r = base(3'b100);
                        r.regWre = 1; r.dbDataSrc = 1; r.wrRegDSrc = 1;
                        r.regDst = 2'b01; r.pcWre = 1;
                        expQ.push_back(r);
                    end
                end
                6'b110100, 6'b110101, 6'b110110: begin
                    bit taken = (op == 6'b110100 && z) || (op == 6'b110101 && !z) ||
                                (op == 6'b110110 && s);
                    expQ.push_back(base(3'b001));
                    r = base(3'b101);
                    r.aluOp = (op == 6'b110110) ? 3'd5 : 3'd1;
                    r.extSel = 1; r.pcWre = 1;
                    r.pcSrc = taken ? 2'b01 : 2'b00;
                    expQ.push_back(r);
                end
                6'b111000: begin r = base(3'b001); r.pcWre = 1; r.pcSrc = 2'b11; expQ.push_back(r); end
                6'b111010: begin
                    r = base(3'b001); r.pcWre = 1; r.pcSrc = 2'b11; r.regWre = 1;
                    r.regDst = 2'b00; r.wrRegDSrc = 0; expQ.push_back(r);
                end
                6'b111001: begin r = base(3'b001); r.pcWre = 1; r.pcSrc = 2'b10; expQ.push_back(r); end
                6'b111111: begin expQ.push_back(base(3'b001)); retire = 0; end
                default:   begin r = base(3'b001); r.pcWre = 1; expQ.push_back(r); end
            endcase
        end
        n = expQ.size() - first;
        if (retire) mCnt = mCnt + 1;
        opcode = op; zero = z; sign = s;
    endtask

    task automatic run(input logic [5:0] op, input logic z, input logic s);
        int n;
        issue(op, z, s, n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Monitor: one comparison per cycle against the head of the expectation queue.
    always @(negedge CLK) begin
        if (monEn && !Reset) begin
            obsT got, exp;
            got = sample();
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL underflow t=%0t got=%h", $time, got);
            end else begin
                exp = expQ.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL cycle t=%0t got=%h exp=%h", $time, got, exp);
                end
            end
        end
    end

    initial begin
        int n;
        obsT h;
        // Reset held three cycles; all controls low throughout.
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_state", 64'(state), 64'd0);
        chk("reset_cnt", 64'(instr_cnt), 64'd0);
        chk("reset_enables", 64'({PCWre, IRWre, RegWre, mWR, mRD, halted}), 64'd0);
        @(posedge CLK); #1;
        Reset = 1'b0;
        monEn = 1;

        run(6'b000000, 0, 0);              // add
        run(6'b110001, 0, 0);              // lw
        chk("cnt_after_add_lw", 64'(instr_cnt), 64'd2);
        run(6'b110100, 1, 0);              // beq taken
        run(6'b110101, 1, 0);              // bne not taken
        run(6'b110110, 0, 1);              // bltz taken
        run(6'b111010, 0, 0);              // jal
        run(6'b111000, 0, 0);              // j
        run(6'b111001, 0, 0);              // jr
        run(6'b101010, 0, 0);              // unknown -> NOP
        chk("cnt_directed", 64'(instr_cnt), 64'd9);

        for (int i = 0; i < 300; i++) begin
            logic [5:0] op;
            if ($urandom_range(0, 1) == 0) op = legalOps[$urandom_range(0, 18)];
            else op = 6'($urandom_range(0, 62));
            run(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        chk("cnt_random", 64'(instr_cnt), 64'(mCnt));

        // Counter wrap: preload all-ones, retire one sw.
        force dut.instrCntQ = 32'hFFFF_FFFF;
        mCnt = 32'hFFFF_FFFF;
        issue(6'b110000, 0, 0, n);
        @(posedge CLK); #1;
        release dut.instrCntQ;
        repeat (n - 1) begin @(posedge CLK); #1; end
        chk("cnt_wrap", 64'(instr_cnt), 64'd0);

        // Halt is absorbing for 20 cycles.
        issue(6'b111111, 0, 0, n);
        for (int i = 0; i < 20; i++) begin
            h = base(3'b000); h.halted = 1; expQ.push_back(h);
        end
        repeat (n + 20) begin @(posedge CLK); #1; end
        chk("halted_flag", 64'(halted), 64'd1);
        chk("queue_drained", 64'(expQ.size()), 64'd0);

        // Asynchronous reset out of HALT.
        monEn = 0;
        Reset = 1'b1;
        #2;
        chk("areset_state", 64'(state), 64'd0);
        chk("areset_halted", 64'(halted), 64'd0);
        chk("areset_cnt", 64'(instr_cnt), 64'd0);
        chk("areset_enables", 64'({PCWre, IRWre, RegWre, mWR}), 64'd0);
        @(posedge CLK); #1;
        Reset = 1'b0;
        mCnt = 0;
        expQ.delete();
        monEn = 1;
        run(6'b010001, 0, 0);              // andi after reset
        chk("cnt_after_reset", 64'(instr_cnt), 64'd1);
        monEn = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
